// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum adder arbiter: width derivation and output FSM encoding.
package psum_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int unsigned calc_w(input int unsigned i_width, input int unsigned f_width);
    return i_width + f_width;
  endfunction

  function automatic int unsigned calc_idw(input int unsigned n_req);
    return $clog2(n_req);
  endfunction

endpackage

// File: rtl/adder_without_en.sv
// Unregistered fixed-point adder: wrapping W-bit sum plus carry-out of the unsigned W+1-bit sum.
module adder_without_en
  import psum_pkg::*;
#(
  parameter int unsigned I_WIDTH = 8,
  parameter int unsigned F_WIDTH = 8
) (
  input  logic [calc_w(I_WIDTH, F_WIDTH)-1:0] a,
  input  logic [calc_w(I_WIDTH, F_WIDTH)-1:0] b,
  output logic [calc_w(I_WIDTH, F_WIDTH)-1:0] sum_c,
  output logic                                carry_c
);

  assign {carry_c, sum_c} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/psum_add_arbiter.sv
// Round-robin arbiter feeding one shared adder; a single-entry output register holds the result
// until downstream accepts it, and can be replaced in the same cycle it is consumed.
module psum_add_arbiter
  import psum_pkg::*;
#(
  parameter int unsigned I_WIDTH = 8,
  parameter int unsigned F_WIDTH = 8,
  parameter int unsigned N_REQ   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_REQ-1:0]                          req_valid_i,
  output logic [N_REQ-1:0]                          req_ready_o,
  input  logic [N_REQ*calc_w(I_WIDTH, F_WIDTH)-1:0] req_a_i,
  input  logic [N_REQ*calc_w(I_WIDTH, F_WIDTH)-1:0] req_b_i,
  output logic                                      res_valid_o,
  input  logic                                      res_ready_i,
  output logic [calc_w(I_WIDTH, F_WIDTH)-1:0]       res_sum_o,
  output logic                                      res_c_o,
  output logic                                      res_ovf_o,
  output logic [calc_idw(N_REQ)-1:0]                res_id_o
);

  localparam int unsigned W   = calc_w(I_WIDTH, F_WIDTH);
  localparam int unsigned IDW = calc_idw(N_REQ);

  // First valid requester strictly after last, wrapping modulo N_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [IDW-1:0]   last);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IDW'((32'(last) + i) % N_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant;
  logic           accept_en;
  logic           xfer;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W-1:0]   sum_c;
  logic           carry_c;
  logic           ovf_c;

  assign accept_en = (state == EMPTY) | res_ready_i;
  assign grant     = rr_pick(req_valid_i, last_grant);
  assign xfer      = accept_en & (|req_valid_i);
  assign a_sel     = req_a_i[32'(grant)*W +: W];
  assign b_sel     = req_b_i[32'(grant)*W +: W];
  assign ovf_c     = (a_sel[W-1] == b_sel[W-1]) & (sum_c[W-1] != a_sel[W-1]);

  adder_without_en #(
    .I_WIDTH (I_WIDTH),
    .F_WIDTH (F_WIDTH)
  ) u_adder (
    .a       (a_sel),
    .b       (b_sel),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  // Handshake strobe for the granted requester only; held low during reset.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && xfer) req_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (res_ready_i && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign res_valid_o = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_o  <= '0;
      res_c_o    <= 1'b0;
      res_ovf_o  <= 1'b0;
      res_id_o   <= '0;
      last_grant <= IDW'(N_REQ - 1);
    end else if (xfer) begin
      res_sum_o  <= sum_c;
      res_c_o    <= carry_c;
      res_ovf_o  <= ovf_c;
      res_id_o   <= grant;
      last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_psum_add_arbiter.sv
// Randomized self-checking bench for psum_add_arbiter against a behavioural reference model.
module tb_psum_add_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_ready_o;
  logic [N*W-1:0]   req_a_i;
  logic [N*W-1:0]   req_b_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [W-1:0]     res_sum_o;
  logic             res_c_o;
  logic             res_ovf_o;
  logic [IDW-1:0]   res_id_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit           m_full;
  int           m_last;
  logic [W-1:0] m_sum;
  logic         m_c;
  logic         m_ovf;
  int           m_id;

  psum_add_arbiter #(.I_WIDTH(8), .F_WIDTH(8), .N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_sum_o   (res_sum_o),
    .res_c_o     (res_c_o),
    .res_ovf_o   (res_ovf_o),
    .res_id_o    (res_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_grant();
    int k;
    if (m_full && !res_ready_i) return -1;
    for (int i = 1; i <= int'(N); i++) begin
      k = (m_last + i) % int'(N);
      if (req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = exp_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_full = 0; m_last = N - 1; m_sum = '0; m_c = 0; m_ovf = 0; m_id = 0;
  endtask

  // Apply the spec's transfer rules to the model, then advance the clock.
  task automatic tick();
    int g;
    logic [W-1:0] a, b;
    logic [W:0] u;
    int s;
    g = exp_grant();
    if (g >= 0) begin
      a = req_a_i[g*W +: W];
      b = req_b_i[g*W +: W];
      u = {1'b0, a} + {1'b0, b};
      s = int'($signed(a)) + int'($signed(b));
      m_sum = u[W-1:0];
      m_c = u[W];
      m_ovf = (s > 32767) || (s < -32768);
      m_id = g;
      m_last = g;
      m_full = 1;
    end else if (res_ready_i) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < int'(N); k++) begin
      req_a_i[k*W +: W] = W'($urandom);
      req_b_i[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic test_reset();
    req_valid_i = 4'hF;
    res_ready_i = 1'b1;
    rand_ops();
    #3;
    checks++; if (req_ready_o !== 4'h0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid_o); end
    checks++; if ({res_sum_o, res_c_o, res_ovf_o, res_id_o} !== '0) begin errors++;
      $display("FAIL reset_outputs got sum=%h c=%b ovf=%b id=%0d exp all zero", res_sum_o, res_c_o, res_ovf_o, res_id_o); end
    req_valid_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_round_robin();
    req_valid_i = 4'hF;
    res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
      checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready_o, exp_ready()); end
      tick();
      checks++; if (res_valid_o !== 1'b1 || int'(res_id_o) != i % 4) begin errors++;
        $display("FAIL rr_id[%0d] got valid=%b id=%0d exp valid=1 id=%0d", i, res_valid_o, res_id_o, i % 4); end
      checks++; if ({res_sum_o, res_c_o, res_ovf_o} !== {m_sum, m_c, m_ovf}) begin errors++;
        $display("FAIL rr_sum[%0d] got %h/%b/%b exp %h/%b/%b", i, res_sum_o, res_c_o, res_ovf_o, m_sum, m_c, m_ovf); end
    end
    req_valid_i = '0;
  endtask

  task automatic test_directed_add();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    logic         eo [3];
    av = '{16'h0180, 16'h7F00, 16'hFF00};
    bv = '{16'h0240, 16'h0200, 16'hFF00};
    es = '{16'h03C0, 16'h8100, 16'hFE00};
    ec = '{1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b1, 1'b0};
    res_ready_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      req_a_i[0 +: W] = av[i];
      req_b_i[0 +: W] = bv[i];
      tick();
      checks++; if ({res_valid_o, res_sum_o, res_c_o, res_ovf_o, res_id_o} !== {1'b1, es[i], ec[i], eo[i], 2'd0}) begin errors++;
        $display("FAIL add[%0d] got v=%b sum=%h c=%b ovf=%b id=%0d exp v=1 sum=%h c=%b ovf=%b id=0",
                 i, res_valid_o, res_sum_o, res_c_o, res_ovf_o, res_id_o, es[i], ec[i], eo[i]); end
    end
    req_valid_i = '0;
  endtask

  task automatic test_stall();
    logic [W-1:0] cap_sum;
    logic cap_c, cap_o;
    res_ready_i = 1'b1;
    req_valid_i = 4'b0010;
    rand_ops();
    tick();
    cap_sum = res_sum_o; cap_c = res_c_o; cap_o = res_ovf_o;
    checks++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd1 || cap_sum !== m_sum) begin errors++;
      $display("FAIL stall_load got v=%b id=%0d sum=%h exp v=1 id=1 sum=%h", res_valid_o, res_id_o, cap_sum, m_sum); end
    res_ready_i = 1'b0;
    req_valid_i = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1;
      checks++; if (req_ready_o !== 4'h0) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0000", i, req_ready_o); end
      tick();
      checks++; if ({res_valid_o, res_id_o, res_sum_o, res_c_o, res_ovf_o} !== {1'b1, 2'd1, cap_sum, cap_c, cap_o}) begin errors++;
        $display("FAIL stall_hold[%0d] got v=%b id=%0d sum=%h exp v=1 id=1 sum=%h", i, res_valid_o, res_id_o, res_sum_o, cap_sum); end
    end
    res_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_release_ready got=%b exp=0100", req_ready_o); end
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd2 || res_sum_o !== m_sum) begin errors++;
      $display("FAIL stall_release got v=%b id=%0d sum=%h exp v=1 id=2 sum=%h", res_valid_o, res_id_o, res_sum_o, m_sum); end
    req_valid_i = '0;
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_reset_midflight();
    res_ready_i = 1'b0;
    req_valid_i = 4'b0001;
    rand_ops();
    tick();
    checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", res_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (res_valid_o !== 1'b0 || req_ready_o !== 4'h0 || res_sum_o !== '0 || res_id_o !== '0) begin errors++;
      $display("FAIL mid_async got v=%b ready=%b sum=%h id=%0d exp v=0 ready=0000 sum=0000 id=0", res_valid_o, req_ready_o, res_sum_o, res_id_o); end
    req_valid_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL mid_no_emit got=%b exp=0", res_valid_o); end
    req_valid_i = 4'b1000;
    res_ready_i = 1'b1;
    rand_ops();
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd3 || res_sum_o !== m_sum) begin errors++;
      $display("FAIL mid_req3 got v=%b id=%0d sum=%h exp v=1 id=3 sum=%h", res_valid_o, res_id_o, res_sum_o, m_sum); end
    req_valid_i = '0;
  endtask

  task automatic test_single_req();
    res_ready_i = 1'b1;
    req_valid_i = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      #1;
      checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=0100", i, req_ready_o); end
      tick();
      checks++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd2 || res_sum_o !== m_sum) begin errors++;
        $display("FAIL single_res[%0d] got v=%b id=%0d sum=%h exp v=1 id=2 sum=%h", i, res_valid_o, res_id_o, res_sum_o, m_sum); end
    end
    req_valid_i = 4'hF;
    #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL single_next_ready got=%b exp=1000", req_ready_o); end
    tick();
    checks++; if (res_id_o !== 2'd3) begin errors++; $display("FAIL single_next_id got=%0d exp=3", res_id_o); end
    req_valid_i = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid_i = N'($urandom_range(0, 15));
      res_ready_i = ($urandom % 4) != 0;
      rand_ops();
      #1;
      checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, req_ready_o, exp_ready()); end
      tick();
      checks++; if (res_valid_o !== m_full) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, res_valid_o, m_full); end
      if (m_full) begin
        checks++; if ({res_sum_o, res_c_o, res_ovf_o} !== {m_sum, m_c, m_ovf} || int'(res_id_o) != m_id) begin errors++;
          $display("FAIL rand_res[%0d] got sum=%h c=%b ovf=%b id=%0d exp sum=%h c=%b ovf=%b id=%0d",
                   i, res_sum_o, res_c_o, res_ovf_o, res_id_o, m_sum, m_c, m_ovf, m_id); end
      end
    end
    req_valid_i = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = '0;
    res_ready_i = 1'b0;
    req_a_i = '0;
    req_b_i = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_directed_add();
    test_stall();
    test_reset_midflight();
    test_single_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_add_arbiter.md
PSUM_ADD_ARBITER -- requirements
Module: psum_add_arbiter

Interface
REQ-001 SHALL have parameter I_WIDTH, default 8: integer bits of each fixed-point operand.
REQ-002 SHALL have parameter F_WIDTH, default 8: fractional bits; W = I_WIDTH+F_WIDTH.
REQ-003 SHALL have parameter N_REQ, default 4: number of requesters, 2..16; IDW = $clog2(N_REQ).
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  N_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_ready_o  output  N_REQ  per-requester accept; at most one bit high.
REQ-008 SHALL have port req_a_i  input  N_REQ*W  signed operand a; requester k occupies bits [k*W +: W].
REQ-009 SHALL have port req_b_i  input  N_REQ*W  signed operand b; same packing.
REQ-010 SHALL have port res_valid_o  output  1  result valid.
REQ-011 SHALL have port res_ready_i  input  1  downstream accept.
REQ-012 SHALL have port res_sum_o  output  W  signed sum, low W bits.
REQ-013 SHALL have port res_c_o  output  1  carry-out, bit W of the unsigned W+1-bit sum.
REQ-014 SHALL have port res_ovf_o  output  1  signed overflow: operand signs equal and the sum sign differs.
REQ-015 SHALL have port res_id_o  output  IDW  index of the requester that produced the result.

Function
REQ-016 SHALL contain a two-state output FSM: EMPTY (res_valid_o=0) and FULL (res_valid_o=1).
REQ-017 SHALL define accept_en = (state==EMPTY) | res_ready_i.
REQ-018 SHALL grant, when accept_en=1 and any req_valid_i bit is set, exactly one requester by round-robin, searching upward from last_grant+1 mod N_REQ.
REQ-019 SHALL drive req_ready_o[g]=1 combinationally for granted index g only; a transfer occurs when valid&ready are both high.
REQ-020 SHALL, on a transfer, register {res_c_o,res_sum_o} = a+b, res_ovf_o, res_id_o=g, and set last_grant=g, all at the next rising edge; latency is 1 cycle.
REQ-021 SHALL move EMPTY->FULL on a transfer.
REQ-022 SHALL hold FULL, with all res_* outputs stable, while res_ready_i=0.
REQ-023 SHALL, in FULL with res_ready_i=1 and a transfer, load the new result and stay FULL, giving back-to-back throughput of 1 result per cycle.
REQ-024 SHALL move FULL->EMPTY on res_ready_i=1 with no transfer.
REQ-025 SHALL leave last_grant unchanged when there is no transfer.
REQ-026 SHALL not advance any state on req_valid_i=0 for all requesters.
REQ-027 SHALL keep last_grant reset value at N_REQ-1, so that requester 0 wins first.
REQ-028 SHALL keep the grant free of dependence on res_valid_o other than through accept_en, and keep req_ready_o independent of req_a_i/req_b_i.
REQ-029 SHALL wrap a W-bit sum modulo 2^W; no saturation.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously force state=EMPTY, res_valid_o=0, res_sum_o=0, res_c_o=0, res_ovf_o=0, res_id_o=0, last_grant=N_REQ-1.
REQ-031 SHALL drive req_ready_o=0 while rst_n=0.
REQ-032 SHALL discard an in-flight FULL result on reset mid-operation; no result is emitted after reset release until a new transfer occurs.

Structure
REQ-033 SHALL place the W, IDW derivation and the FSM state encoding in shared package psum_pkg.
REQ-034 SHALL instantiate exactly one adder_without_en (I_WIDTH, F_WIDTH) sub-module, fed by the granted operand mux, to produce sum and carry.
REQ-035 SHALL implement the round-robin priority search as a function within the module, not as a separate sub-module.

Verification
REQ-036 SHALL verify: all valid, res_ready_i=1 held for 8 cycles -> res_id_o sequence 0,1,2,3,0,1,2,3, with one result per cycle.
REQ-037 SHALL verify: req0 a=0x0180 (1.5), b=0x0240 (2.25) -> res_sum_o=0x03C0, res_c_o=0, res_ovf_o=0 one cycle later.
REQ-038 SHALL verify: a=0x7F00, b=0x0200 -> res_sum_o=0x8100, res_ovf_o=1, res_c_o=0; a=0xFF00, b=0xFF00 -> res_sum_o=0xFE00, res_c_o=1, res_ovf_o=0.
REQ-039 SHALL verify: res_ready_i=0 for 5 cycles with req1 and req2 valid -> outputs stable and req_ready_o=0 during the stall; on release, req2 is granted next.
REQ-040 SHALL verify: rst_n asserted while FULL -> res_valid_o=0 immediately, without a clock; after release with req3 alone valid -> res_id_o=3.
REQ-041 SHALL verify: only req2 valid continuously -> granted every cycle, and last_grant is unaffected by idle requesters.
